unified_memory_arbiter: RTL and testbench
=========================================

Name: unified_memory_arbiter

Overview:
Shares one single-ported word memory (one vectorStorage instance) between the compute core's instruction-fetch port and its data port, so a core can run from one unified memory instead of separate instruction and data memories. Each cycle it grants at most one requester and drives the memory. It returns the synchronous-read result one cycle later to whichever requester issued the access. Data accesses have priority; a starvation limit guarantees that fetch makes forward progress.

Parameters:
BIT_COUNT, 32, address width of all address ports.
WORD_SIZE, 32, data width; byte enables are WORD_SIZE/8 bits.
STARVE_LIMIT, 4, maximum consecutive data grants while IReq is pending before fetch is forced; legal range 1..15.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
IReq  input  1  fetch request; held with stable IAdr until IReady.
IAdr  input  BIT_COUNT  fetch byte address.
IReady  output  1  fetch request accepted this cycle.
IValid  output  1  fetch data valid; asserted the cycle after IReady.
IData  output  WORD_SIZE  fetch read data.
DReq  input  1  data request; held stable until DReady.
DWrite  input  1  1 = store, 0 = load.
DByteEn  input  WORD_SIZE/8  store byte lanes.
DAdr  input  BIT_COUNT  data byte address.
DWriteData  input  WORD_SIZE  store data.
DReady  output  1  data request accepted this cycle.
DValid  output  1  load data valid, or store acknowledge; asserted the cycle after DReady.
DReadData  output  WORD_SIZE  load read data.
MemEn  output  1  memory access enable.
MemWrite  output  1  memory write enable.
MemByteEn  output  WORD_SIZE/8  memory byte enables.
MemAdr  output  BIT_COUNT  memory address.
MemWriteData  output  WORD_SIZE  memory write data.
MemReadData  input  WORD_SIZE  memory read data; valid one cycle after MemEn.
IStallCount  output  16  saturating count of cycles with IReq=1 and IReady=0.

Behaviour:
- Reset (synchronous, active-high, dominates everything): all registers clear.
  - IValid=0, DValid=0, starvation counter=0, IStallCount=0, response owner=NONE.
  - While reset=1: IReady=0, DReady=0, MemEn=0, MemWrite=0, MemByteEn=0.
- Grant logic is combinational from the current requests and the starvation counter. No idle cycle is required between grants; back-to-back grants issue every cycle.
- Data is granted when DReq=1, unless IReq=1 and the starvation counter equals STARVE_LIMIT; in that case fetch is granted.
- Fetch is granted when IReq=1 and data is not granted.
- Fetch grant drives the memory: MemEn=1, MemWrite=0, MemByteEn=0, MemAdr=IAdr.
- Data grant drives the memory: MemEn=1, MemWrite=DWrite, MemByteEn=DWrite?DByteEn:0, MemAdr=DAdr, MemWriteData=DWriteData.
- With no grant: MemEn=0, MemWrite=0, MemByteEn=0. MemAdr and MemWriteData are don't-care but are driven to 0.
- Starvation counter (4-bit):
  - Increments on each data grant while IReq=1.
  - Clears on any fetch grant, and on any cycle with IReq=0.
  - Never exceeds STARVE_LIMIT.
- Response owner register: loads I on a fetch grant, D on a data grant, NONE otherwise. Latency is exactly one cycle:
  - IValid = (owner==I).
  - DValid = (owner==D).
  - IData = MemReadData when owner==I, else 0.
  - DReadData = MemReadData when owner==D and the granted access was a load, else 0.
  - A store raises DValid with DReadData=0.
- A response and a new grant may occur in the same cycle, to the same or the other requester.
- IStallCount increments by 1 per stalled fetch cycle (IReq=1, IReady=0), saturates at 16'hFFFF, and clears only on reset.
- Reset mid-access: any pending response is dropped; IValid and DValid are 0 in the cycle after reset deasserts.
- Requesters must not change address or data while their request is pending and unaccepted; the arbiter does not check this.

Test Plan:
- Reset, then IReq=1, IAdr=0x8, DReq=0 -> IReady=1 and MemEn=1, MemAdr=0x8 in the same cycle; next cycle IValid=1 and IData = mem[2]; IStallCount=0.
- DReq=1, DWrite=1, DAdr=0x10, DByteEn=4'b0011, DWriteData=0xAABBCCDD; next cycle a load from 0x10 -> DValid on both cycles; load returns the low halfword 0xCCDD merged with the prior upper bytes.
- IReq and DReq both held high for 10 cycles, STARVE_LIMIT=4 -> grant pattern D,D,D,D,I repeating; IStallCount=8 after 10 cycles.
- Alternate fetch and load grants on consecutive cycles -> each IValid/DValid lands exactly one cycle after its grant; data is never routed to the wrong port.
- Assert reset for 1 cycle in the cycle after a load grant -> DValid=0 in the following cycles, and MemEn=0 during reset.
- Hold IReq=1 with DReq=1, STARVE_LIMIT=15 -> after 15 data grants fetch is granted; counter returns to 0.

Source files
------------

// File: rtl/unified_memory_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : unified_memory_arbiter_if
// Description : Fetch, data and memory buses of the unified memory arbiter.
//               The slave view belongs to the arbiter. The master view
//               belongs to the core and the memory that sit around it.
// Revision    : 1.0 - initial release
// ============================================================================
interface unified_memory_arbiter_if #(
  parameter int BIT_COUNT = 32,
  parameter int WORD_SIZE = 32
);
  // Instruction-fetch port
  logic                   IReq;
  logic [BIT_COUNT-1:0]   IAdr;
  logic                   IReady;
  logic                   IValid;
  logic [WORD_SIZE-1:0]   IData;

  // Data port
  logic                   DReq;
  logic                   DWrite;
  logic [WORD_SIZE/8-1:0] DByteEn;
  logic [BIT_COUNT-1:0]   DAdr;
  logic [WORD_SIZE-1:0]   DWriteData;
  logic                   DReady;
  logic                   DValid;
  logic [WORD_SIZE-1:0]   DReadData;

  // Shared single-ported memory
  logic                   MemEn;
  logic                   MemWrite;
  logic [WORD_SIZE/8-1:0] MemByteEn;
  logic [BIT_COUNT-1:0]   MemAdr;
  logic [WORD_SIZE-1:0]   MemWriteData;
  logic [WORD_SIZE-1:0]   MemReadData;

  modport slave (
    input  IReq, IAdr,
    output IReady, IValid, IData,
    input  DReq, DWrite, DByteEn, DAdr, DWriteData,
    output DReady, DValid, DReadData,
    output MemEn, MemWrite, MemByteEn, MemAdr, MemWriteData,
    input  MemReadData
  );

  modport master (
    output IReq, IAdr,
    input  IReady, IValid, IData,
    output DReq, DWrite, DByteEn, DAdr, DWriteData,
    input  DReady, DValid, DReadData,
    input  MemEn, MemWrite, MemByteEn, MemAdr, MemWriteData,
    output MemReadData
  );
endinterface
`default_nettype wire

// File: rtl/unified_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : unified_memory_arbiter
// Description : Shares one single-ported synchronous-read memory between the
//               instruction-fetch and data ports. Data wins arbitration. A
//               starvation counter forces a fetch grant after STARVE_LIMIT
//               consecutive data grants while fetch waits. Read data returns
//               one cycle after the grant to the port that issued it.
// Revision    : 1.0 - initial release
// ============================================================================
module unified_memory_arbiter #(
  parameter int BIT_COUNT    = 32,
  parameter int WORD_SIZE    = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  unified_memory_arbiter_if.slave  bus,
  output logic [15:0]              IStallCount
);

  localparam logic [3:0]             c_STARVE_LIMIT = 4'(STARVE_LIMIT);
  localparam logic [15:0]            c_STALL_MAX    = 16'hFFFF;
  localparam logic [BIT_COUNT-1:0]   c_ADR_ZERO     = '0;
  localparam logic [WORD_SIZE-1:0]   c_DATA_ZERO    = '0;
  localparam logic [WORD_SIZE/8-1:0] c_BE_ZERO      = '0;

  // Which requester owns the read data arriving this cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  owner_t      r_owner;
  owner_t      w_ownerNext;
  logic        r_ownerLoad;
  logic [3:0]  r_starveCount;
  logic [15:0] r_iStallCount;
  logic        w_starveHit;
  logic        w_dataGrant;
  logic        w_fetchGrant;

  // Arbitration: data first, unless fetch has waited through the limit
  always_comb begin
    w_starveHit  = bus.IReq && (r_starveCount == c_STARVE_LIMIT);
    w_dataGrant  = !reset && bus.DReq && !w_starveHit;
    w_fetchGrant = !reset && bus.IReq && !w_dataGrant;
  end

  // Memory command and request acknowledges for the granted port
  always_comb begin
    bus.IReady       = w_fetchGrant;
    bus.DReady       = w_dataGrant;
    bus.MemEn        = 1'b0;
    bus.MemWrite     = 1'b0;
    bus.MemByteEn    = c_BE_ZERO;
    bus.MemAdr       = c_ADR_ZERO;
    bus.MemWriteData = c_DATA_ZERO;
    if (w_dataGrant) begin
      bus.MemEn        = 1'b1;
      bus.MemWrite     = bus.DWrite;
      bus.MemByteEn    = bus.DWrite ? bus.DByteEn : c_BE_ZERO;
      bus.MemAdr       = bus.DAdr;
      bus.MemWriteData = bus.DWriteData;
    end else if (w_fetchGrant) begin
      bus.MemEn        = 1'b1;
      bus.MemAdr       = bus.IAdr;
    end
  end

  // Next response owner follows this cycle's grant
  always_comb begin
    w_ownerNext = OWN_NONE;
    if (w_dataGrant) begin
      w_ownerNext = OWN_D;
    end else if (w_fetchGrant) begin
      w_ownerNext = OWN_I;
    end
  end

  // Owner register plus whether the data access was a load
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner     <= OWN_NONE;
      r_ownerLoad <= 1'b0;
    end else begin
      r_owner     <= w_ownerNext;
      r_ownerLoad <= w_dataGrant && !bus.DWrite;
    end
  end

  // Starvation counter: counts data grants that overtook a waiting fetch
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starveCount <= 4'd0;
    end else if (!bus.IReq || w_fetchGrant) begin
      r_starveCount <= 4'd0;
    end else if (w_dataGrant && (r_starveCount != c_STARVE_LIMIT)) begin
      r_starveCount <= r_starveCount + 4'd1;
    end
  end

  // Saturating count of cycles fetch spent waiting
  always_ff @(posedge clk) begin
    if (reset) begin
      r_iStallCount <= 16'd0;
    end else if (bus.IReq && !w_fetchGrant && (r_iStallCount != c_STALL_MAX)) begin
      r_iStallCount <= r_iStallCount + 16'd1;
    end
  end

  // Route the returning read data to its owner only; stores return zero
  always_comb begin
    bus.IValid    = (r_owner == OWN_I);
    bus.DValid    = (r_owner == OWN_D);
    bus.IData     = (r_owner == OWN_I) ? bus.MemReadData : c_DATA_ZERO;
    bus.DReadData = ((r_owner == OWN_D) && r_ownerLoad) ? bus.MemReadData : c_DATA_ZERO;
  end

  assign IStallCount = r_iStallCount;

endmodule
`default_nettype wire

// File: tb/tb_unified_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_unified_memory_arbiter
// Description : Self-checking bench for unified_memory_arbiter with a
//               word-memory model and a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unified_memory_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] IStallCount;
  logic [15:0] IStallCount15;

  int nChecks = 0;
  int nFail   = 0;

  unified_memory_arbiter_if #(.BIT_COUNT(32), .WORD_SIZE(32)) bus ();
  unified_memory_arbiter_if #(.BIT_COUNT(32), .WORD_SIZE(32)) bus15 ();

  unified_memory_arbiter #(.BIT_COUNT(32), .WORD_SIZE(32), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset), .bus(bus), .IStallCount(IStallCount));

  unified_memory_arbiter #(.BIT_COUNT(32), .WORD_SIZE(32), .STARVE_LIMIT(15)) dut15 (
    .clk(clk), .reset(reset), .bus(bus15), .IStallCount(IStallCount15));

  always #5 clk = ~clk;

  function automatic logic [31:0] initWord(input int i);
    return 32'h10203040 + 32'(i) * 32'h01010101;
  endfunction

  // Memory seen by the arbiter: synchronous read, byte-lane writes
  logic [31:0] envMem [0:63];
  bit          memInit = 1'b0;
  always @(posedge clk) begin
    if (!memInit) begin
      for (int i = 0; i < 64; i++) envMem[i] <= initWord(i);
      memInit <= 1'b1;
    end else if (bus.MemEn && bus.MemWrite) begin
      for (int b = 0; b < 4; b++)
        if (bus.MemByteEn[b]) envMem[bus.MemAdr[7:2]][8*b +: 8] <= bus.MemWriteData[8*b +: 8];
    end
    bus.MemReadData <= bus.MemEn ? envMem[bus.MemAdr[7:2]] : $urandom;
  end
  assign bus15.MemReadData = 32'h0;

  // Reference model state
  logic [31:0] refMem [0:63];
  int          mStarve;
  logic [15:0] mStall;
  logic        pendI, pendD;
  logic [31:0] pendIData, pendDData;
  logic        eIReady, eDReady;
  logic [153:0] expVec;

  function automatic logic [153:0] obsVec();
    return {bus.IReady, bus.DReady, bus.MemEn, bus.MemWrite, bus.MemByteEn, bus.MemAdr,
            bus.MemWriteData & {32{~eIReady}}, bus.IValid, bus.DValid, bus.IData,
            bus.DReadData, IStallCount};
  endfunction

  // Predict this cycle's outputs from the rules, then advance to the next cycle
  task automatic predict();
    logic dG, iG, wr;
    logic [3:0]  be;
    logic [31:0] adr, wd;
    logic [5:0]  iIdx, dIdx;
    #1;
    iIdx = bus.IAdr[7:2];
    dIdx = bus.DAdr[7:2];
    dG = !reset && bus.DReq && !(bus.IReq && mStarve == STARVE_LIMIT);
    iG = !reset && bus.IReq && !dG;
    wr = dG && bus.DWrite;
    be = wr ? bus.DByteEn : 4'h0;
    adr = iG ? bus.IAdr : (dG ? bus.DAdr : 32'h0);
    wd = dG ? bus.DWriteData : 32'h0;
    eIReady = iG;
    eDReady = dG;
    expVec = {iG, dG, iG || dG, wr, be, adr, wd, pendI, pendD,
              pendI ? pendIData : 32'h0, pendD ? pendDData : 32'h0, mStall};
    pendI = iG;
    pendD = dG;
    if (iG) pendIData = refMem[iIdx];
    if (dG) begin
      pendDData = wr ? 32'h0 : refMem[dIdx];
      for (int b = 0; b < 4; b++)
        if (wr && bus.DByteEn[b]) refMem[dIdx][8*b +: 8] = bus.DWriteData[8*b +: 8];
    end
    if (reset) begin
      mStarve = 0; mStall = 16'd0; pendI = 1'b0; pendD = 1'b0;
    end else begin
      if (!bus.IReq || iG) mStarve = 0;
      else if (dG && mStarve < STARVE_LIMIT) mStarve++;
      if (bus.IReq && !iG && mStall != 16'hFFFF) mStall++;
    end
  endtask

  task automatic setIdle();
    bus.IReq = 1'b0; bus.IAdr = 32'h0;
    bus.DReq = 1'b0; bus.DWrite = 1'b0; bus.DByteEn = 4'h0; bus.DAdr = 32'h0; bus.DWriteData = 32'h0;
  endtask

  task automatic setLoad(input logic [31:0] a);
    bus.DReq = 1'b1; bus.DWrite = 1'b0; bus.DByteEn = 4'h0; bus.DAdr = a; bus.DWriteData = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.IReq = 1'b1; bus.IAdr = 32'h4; setLoad(32'h8);
    for (int k = 0; k < 2; k++) begin
      predict();
      nChecks++;
      if (obsVec() !== expVec) begin nFail++; $display("FAIL reset cycle %0d: got %h want %h", k, obsVec(), expVec); end
      nChecks++;
      if ({bus.IReady, bus.DReady, bus.MemEn, bus.MemWrite, bus.MemByteEn, bus.IValid, bus.DValid, IStallCount} !== 26'h0) begin
        nFail++; $display("FAIL reset outputs: got %b%b%b%b %h %b%b %h want all zero", bus.IReady, bus.DReady,
                          bus.MemEn, bus.MemWrite, bus.MemByteEn, bus.IValid, bus.DValid, IStallCount);
      end
      @(negedge clk);
    end
    reset = 1'b0;
    setIdle();
  endtask

  task automatic test_fetch();
    logic [31:0] want;
    want = initWord(2);
    bus.IReq = 1'b1; bus.IAdr = 32'h8;
    predict();
    nChecks++;
    if (obsVec() !== expVec) begin nFail++; $display("FAIL fetch grant: got %h want %h", obsVec(), expVec); end
    nChecks++;
    if (!(bus.IReady === 1'b1 && bus.MemEn === 1'b1 && bus.MemAdr === 32'h8)) begin
      nFail++; $display("FAIL fetch cmd: got IReady=%b MemEn=%b MemAdr=%h want 1 1 00000008", bus.IReady, bus.MemEn, bus.MemAdr);
    end
    @(negedge clk);
    setIdle();
    predict();
    nChecks++;
    if (obsVec() !== expVec) begin nFail++; $display("FAIL fetch resp: got %h want %h", obsVec(), expVec); end
    nChecks++;
    if (!(bus.IValid === 1'b1 && bus.IData === want && IStallCount === 16'd0)) begin
      nFail++; $display("FAIL fetch data: got IValid=%b IData=%h stall=%0d want 1 %h 0", bus.IValid, bus.IData, IStallCount, want);
    end
    @(negedge clk);
  endtask

  task automatic test_store_load();
    logic [31:0] prior, want;
    prior = refMem[4];
    want = {prior[31:16], 16'hCCDD};
    bus.DReq = 1'b1; bus.DWrite = 1'b1; bus.DAdr = 32'h10; bus.DByteEn = 4'b0011; bus.DWriteData = 32'hAABBCCDD;
    for (int k = 0; k < 3; k++) begin
      predict();
      nChecks++;
      if (obsVec() !== expVec) begin nFail++; $display("FAIL store_load cycle %0d: got %h want %h", k, obsVec(), expVec); end
      if (k == 1) begin
        nChecks++;
        if (!(bus.DValid === 1'b1 && bus.DReadData === 32'h0)) begin
          nFail++; $display("FAIL store ack: got DValid=%b DReadData=%h want 1 00000000", bus.DValid, bus.DReadData);
        end
      end
      if (k == 2) begin
        nChecks++;
        if (!(bus.DValid === 1'b1 && bus.DReadData === want)) begin
          nFail++; $display("FAIL load merged: got DValid=%b DReadData=%h want 1 %h", bus.DValid, bus.DReadData, want);
        end
      end
      @(negedge clk);
      if (k == 0) setLoad(32'h10);
      else setIdle();
    end
  endtask

  task automatic test_alternate();
    for (int k = 0; k < 9; k++) begin
      setIdle();
      if (k < 8) begin
        if (k % 2 == 0) begin bus.IReq = 1'b1; bus.IAdr = 32'(k * 4); end
        else setLoad(32'((32 + k) * 4));
      end
      predict();
      nChecks++;
      if (obsVec() !== expVec) begin nFail++; $display("FAIL alternate cycle %0d: got %h want %h", k, obsVec(), expVec); end
      @(negedge clk);
    end
  endtask

  task automatic test_starve();
    reset = 1'b1; setIdle();
    predict();
    @(negedge clk);
    reset = 1'b0;
    bus.IReq = 1'b1; bus.IAdr = 32'h20; setLoad(32'h40);
    for (int k = 0; k < 10; k++) begin
      predict();
      nChecks++;
      if (obsVec() !== expVec) begin nFail++; $display("FAIL starve cycle %0d: got %h want %h", k, obsVec(), expVec); end
      nChecks++;
      if (bus.IReady !== ((k % 5) == 4) || bus.DReady !== ((k % 5) != 4)) begin
        nFail++; $display("FAIL starve pattern %0d: got I=%b D=%b want I=%b", k, bus.IReady, bus.DReady, (k % 5) == 4);
      end
      @(negedge clk);
    end
    setIdle();
    predict();
    nChecks++;
    if (obsVec() !== expVec) begin nFail++; $display("FAIL starve tail: got %h want %h", obsVec(), expVec); end
    nChecks++;
    if (IStallCount !== 16'd8) begin nFail++; $display("FAIL starve stall count: got %0d want 8", IStallCount); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    setLoad(32'h24);
    for (int k = 0; k < 3; k++) begin
      predict();
      nChecks++;
      if (obsVec() !== expVec) begin nFail++; $display("FAIL reset_mid cycle %0d: got %h want %h", k, obsVec(), expVec); end
      if (k == 1) begin
        nChecks++;
        if (bus.MemEn !== 1'b0) begin nFail++; $display("FAIL reset_mid MemEn: got %b want 0", bus.MemEn); end
      end
      if (k == 2) begin
        nChecks++;
        if (bus.DValid !== 1'b0 || bus.IValid !== 1'b0) begin
          nFail++; $display("FAIL reset_mid drop: got DValid=%b IValid=%b want 0 0", bus.DValid, bus.IValid);
        end
      end
      @(negedge clk);
      if (k == 0) begin reset = 1'b1; setIdle(); end
      else reset = 1'b0;
    end
  endtask

  task automatic test_random();
    logic iPend, dPend;
    iPend = 1'b0; dPend = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!iPend) begin
        bus.IReq = ($urandom_range(0, 2) != 0);
        bus.IAdr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      end
      if (!dPend) begin
        bus.DReq = ($urandom_range(0, 2) != 0);
        bus.DWrite = $urandom_range(0, 1) == 1;
        bus.DByteEn = 4'($urandom);
        bus.DAdr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        bus.DWriteData = $urandom;
      end
      predict();
      nChecks++;
      if (obsVec() !== expVec) begin nFail++; $display("FAIL random cycle %0d: got %h want %h", k, obsVec(), expVec); end
      iPend = bus.IReq && !eIReady;
      dPend = bus.DReq && !eDReady;
      @(negedge clk);
    end
    setIdle();
  endtask

  task automatic test_starve15();
    bus15.IReq = 1'b1; bus15.DReq = 1'b1;
    for (int k = 0; k < 17; k++) begin
      #1;
      nChecks++;
      if (bus15.IReady !== (k == 15) || bus15.DReady !== (k != 15)) begin
        nFail++; $display("FAIL starve15 cycle %0d: got I=%b D=%b want I=%b", k, bus15.IReady, bus15.DReady, k == 15);
      end
      if (k == 16) begin
        nChecks++;
        if (IStallCount15 !== 16'd15) begin nFail++; $display("FAIL starve15 stall count: got %0d want 15", IStallCount15); end
      end
      @(negedge clk);
    end
    bus15.IReq = 1'b0; bus15.DReq = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) refMem[i] = initWord(i);
    reset = 1'b1;
    setIdle();
    bus15.IReq = 1'b0; bus15.IAdr = 32'h0; bus15.DReq = 1'b0; bus15.DWrite = 1'b0;
    bus15.DByteEn = 4'h0; bus15.DAdr = 32'h0; bus15.DWriteData = 32'h0;
    mStarve = 0; mStall = 16'd0; pendI = 1'b0; pendD = 1'b0;
    pendIData = 32'h0; pendDData = 32'h0; eIReady = 1'b0; eDReady = 1'b0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_fetch();
    test_store_load();
    test_alternate();
    test_starve();
    test_reset_mid();
    test_random();
    test_starve15();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
`default_nettype wire
